nasti_narrower_reader: RTL

Read-direction companion of the NASTI narrower: it accepts AR/R traffic from a master on a wide data bus (MASTER_DATA_WIDTH) and forwards it to a slave on a narrow bus (SLAVE_DATA_WIDTH). Each master read burst becomes one slave burst of narrowed size and scaled length. Narrow R beats are packed back into wide master beats. One transaction is outstanding at a time. The block sits between a wide NASTI interconnect port and a narrow peripheral or memory slave.

---
 rtl/nasti_narrower_reader.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/nasti_narrower_reader.sv
// NASTI read-path narrower: splits wide AR bursts into narrow slave bursts
// and packs narrow R beats back into wide master beats.
module nasti_narrower_reader #(
    parameter int ID_WIDTH          = 2,
    parameter int ADDR_WIDTH        = 32,
    parameter int MASTER_DATA_WIDTH = 64,
    parameter int SLAVE_DATA_WIDTH  = 32,
    parameter int USER_WIDTH        = 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [ID_WIDTH-1:0]          master_ar_id,
    input  logic [ADDR_WIDTH-1:0]        master_ar_addr,
    input  logic [7:0]                   master_ar_len,
    input  logic [2:0]                   master_ar_size,
    input  logic [1:0]                   master_ar_burst,
    input  logic                         master_ar_lock,
    input  logic [3:0]                   master_ar_cache,
    input  logic [2:0]                   master_ar_prot,
    input  logic [3:0]                   master_ar_qos,
    input  logic [3:0]                   master_ar_region,
    input  logic [USER_WIDTH-1:0]        master_ar_user,
    input  logic                         master_ar_valid,
    output logic                         master_ar_ready,
    output logic [ID_WIDTH-1:0]          master_r_id,
    output logic [MASTER_DATA_WIDTH-1:0] master_r_data,
    output logic [1:0]                   master_r_resp,
    output logic                         master_r_last,
    output logic [USER_WIDTH-1:0]        master_r_user,
    output logic                         master_r_valid,
    input  logic                         master_r_ready,
    output logic [ID_WIDTH-1:0]          slave_ar_id,
    output logic [ADDR_WIDTH-1:0]        slave_ar_addr,
    output logic [7:0]                   slave_ar_len,
    output logic [2:0]                   slave_ar_size,
    output logic [1:0]                   slave_ar_burst,
    output logic                         slave_ar_lock,
    output logic [3:0]                   slave_ar_cache,
    output logic [2:0]                   slave_ar_prot,
    output logic [3:0]                   slave_ar_qos,
    output logic [3:0]                   slave_ar_region,
    output logic [USER_WIDTH-1:0]        slave_ar_user,
    output logic                         slave_ar_valid,
    input  logic                         slave_ar_ready,
    input  logic [ID_WIDTH-1:0]          slave_r_id,
    input  logic [SLAVE_DATA_WIDTH-1:0]  slave_r_data,
    input  logic [1:0]                   slave_r_resp,
    input  logic                         slave_r_last,
    input  logic [USER_WIDTH-1:0]        slave_r_user,
    input  logic                         slave_r_valid,
    output logic                         slave_r_ready
);
    localparam int MCS   = $clog2(MASTER_DATA_WIDTH / 8);
    localparam int SCS   = $clog2(SLAVE_DATA_WIDTH / 8);
    localparam int NLANE = MASTER_DATA_WIDTH / SLAVE_DATA_WIDTH;
    localparam int LW    = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam int OW    = MCS + 2;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [USER_WIDTH-1:0] user;
    } req_t;

    state_t                       state, state_nxt;
    req_t                         req;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic [MASTER_DATA_WIDTH-1:0] asm_data;
    logic [1:0]                   resp_acc;
    logic [7:0]                   m_cnt;

    logic                         ar_hs, s_ar_hs, s_r_hs, m_r_hs;
    logic                         wide;
    logic [2:0]                   sh;
    logic [MCS-1:0]               size_mask;
    logic [15:0]                  ratio, lane_off, s_len;
    logic [ADDR_WIDTH-1:0]        step, r_next;
    logic [OW-1:0]                off, beat_bytes;
    logic                         final_beat;
    logic [LW-1:0]                lane;
    logic [MASTER_DATA_WIDTH-1:0] merged;
    logic [1:0]                   resp_max;

    assign ar_hs   = master_ar_valid && master_ar_ready;
    assign s_ar_hs = slave_ar_valid && slave_ar_ready;
    assign s_r_hs  = slave_r_valid && slave_r_ready;
    assign m_r_hs  = master_r_valid && master_r_ready;

    always_comb begin
        wide       = req.size > 3'(SCS);
        sh         = wide ? req.size - 3'(SCS) : 3'd0;
        size_mask  = MCS'((32'd1 << req.size) - 32'd1);
        ratio      = 16'd1 << sh;
        lane_off   = 16'((req.addr[MCS-1:0] & size_mask) >> SCS);
        s_len      = wide ? ({8'd0, req.len} << sh) + ratio - lane_off - 16'd1
                          : {8'd0, req.len};
        step       = wide ? ADDR_WIDTH'(SLAVE_DATA_WIDTH / 8)
                          : ADDR_WIDTH'(1) << req.size;
        r_next     = (r_addr & ~(step - ADDR_WIDTH'(1))) + step;
        off        = OW'(r_addr[MCS-1:0] & size_mask);
        beat_bytes = OW'(1) << req.size;
        // last narrow beat that still falls inside the current wide beat
        final_beat = (off + OW'(step)) >= beat_bytes;
        lane       = LW'((r_addr >> SCS) & ADDR_WIDTH'(NLANE - 1));
        merged     = asm_data;
        for (int i = 0; i < NLANE; i++) begin
            if (lane == LW'(i))
                merged[i*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH] = slave_r_data;
        end
        resp_max   = (slave_r_resp > resp_acc) ? slave_r_resp : resp_acc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (ar_hs) state_nxt = S_AR;
            S_AR:   if (s_ar_hs) state_nxt = S_R;
            S_R:    if (m_r_hs && master_r_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req            <= '0;
            r_addr         <= '0;
            asm_data       <= '0;
            resp_acc       <= '0;
            m_cnt          <= '0;
            master_r_valid <= 1'b0;
            master_r_data  <= '0;
            master_r_resp  <= '0;
            master_r_user  <= '0;
        end else begin
            if (ar_hs) begin
                req <= '{id: master_ar_id, addr: master_ar_addr,
                         len: master_ar_len, size: master_ar_size,
                         burst: master_ar_burst, lock: master_ar_lock,
                         cache: master_ar_cache, prot: master_ar_prot,
                         qos: master_ar_qos, region: master_ar_region,
                         user: master_ar_user};
                r_addr   <= master_ar_addr;
                m_cnt    <= '0;
                asm_data <= '0;
                resp_acc <= '0;
            end
            if (m_r_hs) begin
                master_r_valid <= 1'b0;
                m_cnt          <= m_cnt + 8'd1;
            end
            if (s_r_hs) begin
                r_addr <= r_next;
                if (final_beat) begin
                    master_r_valid <= 1'b1;
                    master_r_data  <= merged;
                    master_r_resp  <= resp_max;
                    master_r_user  <= slave_r_user;
                    asm_data       <= '0;
                    resp_acc       <= '0;
                end else begin
                    asm_data <= merged;
                    resp_acc <= resp_max;
                end
            end
        end
    end

    assign master_ar_ready = (state == S_IDLE);
    assign slave_ar_valid  = (state == S_AR);
    assign slave_r_ready   = (state == S_R) && (!master_r_valid || master_r_ready);
    assign master_r_id     = req.id;
    assign master_r_last   = master_r_valid && (m_cnt == req.len);

    assign slave_ar_id     = req.id;
    assign slave_ar_addr   = req.addr;
    assign slave_ar_len    = s_len[7:0];
    assign slave_ar_size   = wide ? 3'(SCS) : req.size;
    assign slave_ar_burst  = req.burst;
    assign slave_ar_lock   = req.lock;
    assign slave_ar_cache  = req.cache;
    assign slave_ar_prot   = req.prot;
    assign slave_ar_qos    = req.qos;
    assign slave_ar_region = req.region;
    assign slave_ar_user   = req.user;

    logic unused_ok;
    assign unused_ok = ^{slave_r_id, slave_r_last, s_len[15:8]};

    logic [2:0]  ar_sh;
    logic [15:0] ar_beats;
    always_comb begin
        ar_sh    = (master_ar_size > 3'(SCS)) ? master_ar_size - 3'(SCS) : 3'd0;
        ar_beats = ({8'd0, master_ar_len} + 16'd1) << ar_sh;
    end

    always_ff @(posedge clk) begin
        if (rstn && ar_hs) begin
            assert (master_ar_burst == BURST_INCR)
                else $fatal(1, "master AR burst is not INCR");
            assert (master_ar_size <= 3'(MCS))
                else $fatal(1, "master AR size exceeds bus width");
            assert (ar_beats <= 16'd256)
                else $fatal(1, "narrowed burst longer than 256 beats");
        end
    end
endmodule
